// File: rtl/mux_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_arb_pkg                                                          |
// | Shared state encoding and requester IDs for the 2:1 mux arbiter.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GX   = 2'b01,
        GY   = 2'b10
    } arb_state_e;

    // Requester IDs follow the mux select polarity: 1 selects x.
    localparam logic REQ_X = 1'b1;
    localparam logic REQ_Y = 1'b0;

    localparam int CNT_W = 4;

    function automatic arb_state_e grant_of(input logic id);
        return (id == REQ_X) ? GX : GY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_hold_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_hold_counter                                                     |
// | Saturating 4-bit grant-hold counter with clear, enable and at_max.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module arb_hold_counter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic at_max_o
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != C_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mux21_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux21_arbiter                                                        |
// | Round-robin arbiter driving the select of a 2:1 mux (1 = x, 0 = y).  |
// | Optional starvation timeout: define MUX_ARB_TIMEOUT_EN.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mux21_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_x,
    input  logic req_y,
    output logic gnt_x,
    output logic gnt_y,
    output logic sel,
    output logic valid
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       gnt_x_q;
    logic       gnt_y_q;
    logic       sel_q;
    logic       valid_q;
    logic       w_at_max;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_x && req_y) begin
                    state_d = grant_of(~last_q);
                end else if (req_x) begin
                    state_d = GX;
                end else if (req_y) begin
                    state_d = GY;
                end
            end
            GX: begin
                if (req_x && !(w_at_max && req_y)) begin
                    state_d = GX;
                end else if (req_y) begin
                    state_d = GY;
                end else begin
                    state_d = IDLE;
                end
            end
            GY: begin
                if (req_y && !(w_at_max && req_x)) begin
                    state_d = GY;
                end else if (req_x) begin
                    state_d = GX;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MUX_ARB_TIMEOUT_EN
    logic w_enter;
    logic w_stay;

    // A handoff is an entry too, so the new owner starts a fresh hold window.
    assign w_enter = (state_d != IDLE) && (state_d != state_q);
    assign w_stay  = (state_d != IDLE) && (state_d == state_q);

    arb_hold_counter #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (w_enter),
        .en_i     (w_stay),
        .at_max_o (w_at_max)
    );
`else
    // Without the timeout HOLD_MAX has no effect; this term is constant 0.
    assign w_at_max = (HOLD_MAX < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= REQ_Y;
            gnt_x_q <= 1'b0;
            gnt_y_q <= 1'b0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_x_q <= (state_d == GX);
            gnt_y_q <= (state_d == GY);
            valid_q <= (state_d != IDLE);
            if (state_d == GX) begin
                sel_q  <= REQ_X;
                last_q <= REQ_X;
            end else if (state_d == GY) begin
                sel_q  <= REQ_Y;
                last_q <= REQ_Y;
            end
        end
    end

    assign gnt_x = gnt_x_q;
    assign gnt_y = gnt_y_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux21_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mux21_arbiter                                                     |
// | Self-checking bench for mux21_arbiter against an ownership model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mux21_arbiter;

    localparam int HOLD_MAX = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic req_x;
    logic req_y;
    logic gnt_x;
    logic gnt_y;
    logic sel;
    logic valid;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the mux (0 none, 1 X, 2 Y), who had it last,
    // how long the owner has held it, and the select value.
    int m_owner;
    bit m_last_x;
    int m_hold;
    bit m_sel;

    mux21_arbiter #(
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req_x (req_x),
        .req_y (req_y),
        .gnt_x (gnt_x),
        .gnt_y (gnt_y),
        .sel   (sel),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_last_x = 1'b0;
        m_hold   = 0;
        m_sel    = 1'b0;
    endtask

    task automatic model_step(input bit wx, input bit wy);
        int nxt;
        bit forced;
        forced = TIMEOUT && (m_hold == HOLD_MAX - 1);
        nxt = 0;
        if (m_owner == 0) begin
            if (wx && wy) nxt = m_last_x ? 2 : 1;
            else if (wx)  nxt = 1;
            else if (wy)  nxt = 2;
        end else if (m_owner == 1) begin
            if (wx && !(forced && wy)) nxt = 1;
            else if (wy)               nxt = 2;
        end else begin
            if (wy && !(forced && wx)) nxt = 2;
            else if (wx)               nxt = 1;
        end
        if (nxt != 0 && nxt == m_owner) begin
            if (m_hold < HOLD_MAX - 1) m_hold++;
        end else if (nxt != 0) begin
            m_hold = 0;
        end
        if (nxt == 1) begin
            m_last_x = 1'b1;
            m_sel    = 1'b1;
        end else if (nxt == 2) begin
            m_last_x = 1'b0;
            m_sel    = 1'b0;
        end
        m_owner = nxt;
    endtask

    task automatic check_all();
        check("gnt_x", gnt_x, m_owner == 1);
        check("gnt_y", gnt_y, m_owner == 2);
        check("sel", sel, m_sel);
        check("valid", valid, m_owner != 0);
        check("exclusive", gnt_x & gnt_y, 1'b0);
        check("valid_or", valid, gnt_x | gnt_y);
        if (gnt_x) check("sel_with_gx", sel, 1'b1);
    endtask

    // One clock: model follows the inputs the DUT sampled, then compare.
    task automatic step();
        @(posedge clk);
        model_step(req_x, req_y);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_all();
    endtask

    initial begin
        int x_run;
        bit x_done;
        rst_n = 1'b0;
        req_x = 1'b0;
        req_y = 1'b0;
        model_reset();

        // Reset, then idle for 10 cycles
        do_reset();
        repeat (10) step();

        // X alone, then release: sel must stay at 1
        req_x = 1'b1;
        step();
        check("x_only_gnt", gnt_x, 1'b1);
        req_x = 1'b0;
        step();
        check("x_release_sel", sel, 1'b1);
        repeat (2) step();

        // Asynchronous reset in the middle of a grant
        req_x = 1'b1;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_gnt_x", gnt_x, 1'b0);
        check("async_rst_valid", valid, 1'b0);
        check("async_rst_sel", sel, 1'b0);
        req_x = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step();

        // Tie from reset goes to X, then direct handoff to Y
        do_reset();
        req_x = 1'b1;
        req_y = 1'b1;
        step();
        check("tie_first_x", gnt_x, 1'b1);
        repeat (2) step();
        req_x = 1'b0;
        step();
        check("handoff_gnt_y", gnt_y, 1'b1);
        check("handoff_gnt_x", gnt_x, 1'b0);
        req_y = 1'b0;
        repeat (2) step();

        // Alternating one-cycle ties from IDLE: X, Y, X, Y
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_x = 1'b1;
            req_y = 1'b1;
            step();
            check("alt_tie_x", gnt_x, (i % 2) == 0);
            check("alt_tie_y", gnt_y, (i % 2) == 1);
            req_x = 1'b0;
            req_y = 1'b0;
            step();
        end

        // X held continuously with Y joining: timeout forces handoff
        do_reset();
        req_x = 1'b1;
        step();
        req_y = 1'b1;
        x_run  = 1;
        x_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (!gnt_x) x_done = 1'b1;
            else if (!x_done) x_run++;
        end
        check_int("x_hold_run", x_run, TIMEOUT ? HOLD_MAX : 9);
        req_x = 1'b0;
        repeat (3) step();
        req_y = 1'b0;
        repeat (2) step();

        // Random requests against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_x = ($urandom_range(0, 3) != 0);
            req_y = ($urandom_range(0, 2) != 0);
            step();
        end
        req_x = 1'b0;
        req_y = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux21_arbiter.md
# mux21_arbiter

Round-robin arbiter that shares the 2:1 mux datapath between two requesters, X and Y. Samples per-requester request lines, issues one-hot registered grants, and drives the mux select so that the granted requester's data reaches the mux output. Sits directly in front of the 2:1 mux: `sel` connects to the mux select input, where 1 selects x and 0 selects y.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive grant cycles before forced handoff, when `MUX_ARB_TIMEOUT_EN` is defined; legal range 2..15.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_x` input 1: requester X wants the mux; held high for as long as it needs it.
- `req_y` input 1: requester Y, same semantics.
- `gnt_x` output 1: X owns the mux.
- `gnt_y` output 1: Y owns the mux.
- `sel` output 1: mux select; 1 selects x, 0 selects y.
- `valid` output 1: the mux output carries a granted requester's data; equals `gnt_x | gnt_y`.

## Operation
- FSM states:
  - IDLE: no grant.
  - GX: X granted.
  - GY: Y granted.
- Priority pointer `last`: records the most recently granted requester.
- Reset values: state IDLE, `gnt_x`=0, `gnt_y`=0, `sel`=0, `valid`=0, `last`=Y (so X wins the first tie), hold counter 0.
- Transitions from IDLE:
  - Only `req_x` → GX.
  - Only `req_y` → GY.
  - Both → the requester not equal to `last`.
  - Neither → stay IDLE.
- Transitions from GX:
  - `req_x` high → stay GX.
  - `req_x` low and `req_y` high → GY, a direct handoff with no IDLE cycle.
  - Both low → IDLE.
- GY is symmetric to GX.
- `last` updates on every entry to GX or GY.
- `sel` is 1 in GX and 0 in GY. In IDLE it holds its previous value, so there are no glitching select changes while idle.
- `gnt_x` and `gnt_y` are never high together, in any cycle, including across a handoff.
- Reset asserted mid-grant: all outputs drop immediately to their reset values (asynchronous). After release, arbitration restarts from IDLE with `last`=Y.

## Timing
- All outputs are registered.
- Grant latency: a request sampled at edge k gives a grant visible after edge k, i.e. during cycle k+1.
- Release latency: a request dropping before edge n gives the grant low after edge n. On a handoff, the other grant rises at that same edge.
- Minimum grant length is 1 cycle.
- `sel` changes only at the edge where the grant changes owner.
- Hold counter: 4 bits, cleared on every entry to GX or GY, incremented each cycle the grant is held, saturating at `HOLD_MAX`-1.

## Configuration
- Macro: `MUX_ARB_TIMEOUT_EN`.
- Defined:
  - In GX, when the counter equals `HOLD_MAX`-1 and `req_y` is high, the next edge forces GY even though `req_x` is still high.
  - GY is symmetric.
  - If the other requester is idle, the counter saturates and the grant continues indefinitely.
- Undefined:
  - Counter logic is not compiled.
  - A grant is held until its requester drops, with no starvation protection.
  - `HOLD_MAX` is ignored.

## Structure
- Shared package `mux_arb_pkg` holds:
  - State encoding constants IDLE=2'b00, GX=2'b01, GY=2'b10.
  - Requester ID constants REQ_X=1'b1, REQ_Y=1'b0, matching the `sel` polarity.
- One sub-module, `arb_hold_counter`: saturating 4-bit counter with clear, enable and `at_max` output, instantiated only under `MUX_ARB_TIMEOUT_EN`.
- The FSM, `last` pointer and output registers stay in the top module.

## Test plan
- Reset then no requests: `gnt_x`=`gnt_y`=`valid`=`sel`=0 for 10 cycles. Asserting `rst_n`=0 mid-GX drops `gnt_x` without waiting for a clock edge.
- `req_x`=1 only: `gnt_x`=1 and `sel`=1 one cycle later. Dropping `req_x`: `gnt_x`=0 after the next edge, `sel` stays 1.
- `req_x`=`req_y`=1 together from reset: GX first. Drop `req_x`: GY the next cycle, `gnt_y` rising at the same edge `gnt_x` falls.
- Alternating ties: both asserted for 1 cycle from IDLE, released, repeated 4 times → grants X, Y, X, Y.
- `MUX_ARB_TIMEOUT_EN` with `HOLD_MAX`=4: `req_x` held continuously, `req_y` rising while X is granted → forced handoff to Y after X has held the grant for 4 cycles. With the macro undefined, the same stimulus keeps X granted until `req_x` drops.
- Throughout all of the above, assert every cycle: `gnt_x & gnt_y`=0, `valid` == `gnt_x | gnt_y`, and `sel` == 1 whenever `gnt_x`=1.
